// File: rtl/pwm_line_drive.sv
// Line-following H-bridge drive: sensor steering decode, soft-start PWM,
// over-current debounce trip and line-lost timeout with latched faults.
module pwm_line_drive #(
  parameter int PWM_PERIOD   = 1666667,
  parameter int DW           = $clog2(PWM_PERIOD + 1),
  parameter int RAMP_STEP    = 16667,
  parameter int OC_CH        = 2,
  parameter int OC_CYCLES    = 20000000,
  parameter int LOST_PERIODS = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DW-1:0]    duty,
  input  logic [3:0]       ips,
  input  logic [OC_CH-1:0] oc_n,
  input  logic             clear_fault,
  output logic [3:0]       motor,
  output logic [1:0]       fault,
  output logic [2:0]       state,
  output logic [DW-1:0]    cur_duty
);

  localparam int OW = $clog2(OC_CYCLES + 1);
  localparam int LW = $clog2(LOST_PERIODS + 1);
  localparam int STEP_C = (RAMP_STEP > PWM_PERIOD) ? PWM_PERIOD : RAMP_STEP;
  localparam logic [DW-1:0] PER_W  = DW'(PWM_PERIOD);
  localparam logic [DW-1:0] LAST_W = DW'(PWM_PERIOD - 1);
  localparam logic [DW:0]   STEP_W = (DW + 1)'(STEP_C);
  localparam logic [OW-1:0] OC_MAX = OW'(OC_CYCLES);
  localparam logic [LW-1:0] LP_MAX = LW'(LOST_PERIODS);

  localparam logic [3:0] M_FWD    = 4'b1010;
  localparam logic [3:0] M_LEFT   = 4'b1000;
  localparam logic [3:0] M_RIGHT  = 4'b0010;
  localparam logic [3:0] M_PLEFT  = 4'b1001;
  localparam logic [3:0] M_PRIGHT = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_RUN   = 3'd2,
    S_LOST  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    D_NONE  = 2'd0,
    D_LEFT  = 2'd1,
    D_RIGHT = 2'd2
  } dir_t;

  logic [3:0]       ips_m_q, ips_s_q;
  logic [OC_CH-1:0] oc_m_q, oc_s_q;

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [3:0]    motor_q, motor_d;
  logic [1:0]    fault_q, fault_d;
  logic [DW-1:0] cur_duty_q, cur_duty_d;
  logic [DW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [OW-1:0] oc_cnt_q, oc_cnt_d;
  logic [LW-1:0] lost_cnt_q, lost_cnt_d;

  logic          c_zero, c_left, c_right, c_lost, c_fwd;
  logic [3:0]    steer, lost_code;
  logic [DW-1:0] target, ramp_val;
  logic [DW:0]   ramp_sum;
  logic [LW-1:0] lost_inc;
  logic          wrap, oc_any;

  // Sync regs idle high: no sensor and no over-current.
  always_ff @(posedge clk) begin
    if (rst) begin
      ips_m_q <= '1;
      ips_s_q <= '1;
      oc_m_q  <= '1;
      oc_s_q  <= '1;
    end else begin
      ips_m_q <= ips;
      ips_s_q <= ips_m_q;
      oc_m_q  <= oc_n;
      oc_s_q  <= oc_m_q;
    end
  end

  assign c_zero  = (ips_s_q == 4'b0000);
  assign c_left  = !ips_s_q[3] && !c_zero;
  assign c_right = ips_s_q[3] && !ips_s_q[0];
  assign c_lost  = (ips_s_q == 4'b1111);
  assign c_fwd   = ips_s_q[3] && ips_s_q[0] && !c_lost;

  always_comb begin
    steer = M_FWD;
    dir_d = dir_q;
    unique case (1'b1)
      c_zero: begin
        unique case (dir_q)
          D_LEFT:  steer = M_LEFT;
          D_RIGHT: steer = M_RIGHT;
          default: steer = M_FWD;
        endcase
      end
      c_left: begin
        steer = ips_s_q[2] ? M_PLEFT : M_LEFT;
        dir_d = D_LEFT;
      end
      c_right: begin
        steer = ips_s_q[1] ? M_PRIGHT : M_RIGHT;
        dir_d = D_RIGHT;
      end
      c_lost:  steer = 4'b0000;
      c_fwd:   steer = M_FWD;
      default: steer = M_FWD;
    endcase
  end

  always_comb begin
    unique case (dir_q)
      D_LEFT:  lost_code = M_PLEFT;
      D_RIGHT: lost_code = M_PRIGHT;
      default: lost_code = M_FWD;
    endcase
  end

  assign target   = (duty > PER_W) ? PER_W : duty;
  assign wrap     = (pwm_cnt_q == LAST_W);
  assign oc_any   = ~&oc_s_q;
  assign ramp_sum = {1'b0, cur_duty_q} + STEP_W;
  assign ramp_val = (ramp_sum > {1'b0, target}) ? target : ramp_sum[DW-1:0];
  assign lost_inc = lost_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    cur_duty_d = cur_duty_q;
    lost_cnt_d = lost_cnt_q;
    pwm_cnt_d  = wrap ? '0 : pwm_cnt_q + 1'b1;
    oc_cnt_d   = '0;
    if (oc_any) begin
      oc_cnt_d = (oc_cnt_q == OC_MAX) ? oc_cnt_q : oc_cnt_q + 1'b1;
    end
    if (state_q == S_FAULT) begin
      if (clear_fault) begin
        state_d   = S_IDLE;
        fault_d   = 2'b00;
        pwm_cnt_d = '0;
        oc_cnt_d  = '0;
      end
    end else if (oc_cnt_q == OC_MAX) begin
      state_d = S_FAULT;
      fault_d = 2'b01;
    end else if (state_q == S_LOST && wrap && lost_inc == LP_MAX) begin
      state_d = S_FAULT;
      fault_d = 2'b10;
    end else if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_RAMP;
        S_RAMP: begin
          if (c_lost) begin
            state_d = S_LOST;
          end else if (wrap) begin
            cur_duty_d = ramp_val;
            if (ramp_val == target) state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (c_lost) begin
            state_d = S_LOST;
          end else if (wrap) begin
            if (target > cur_duty_q) state_d = S_RAMP;
            else cur_duty_d = target;
          end
        end
        S_LOST: begin
          if (!c_lost) state_d = S_RUN;
          else if (wrap) lost_cnt_d = lost_inc;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d != S_LOST) lost_cnt_d = '0;
    if (state_d == S_IDLE || state_d == S_FAULT) cur_duty_d = '0;
    motor_d = 4'b0000;
    if ((state_d == S_RAMP || state_d == S_RUN || state_d == S_LOST) &&
        pwm_cnt_q < cur_duty_q) begin
      motor_d = (state_d == S_LOST) ? lost_code : steer;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dir_q      <= D_NONE;
      motor_q    <= '0;
      fault_q    <= '0;
      cur_duty_q <= '0;
      pwm_cnt_q  <= '0;
      oc_cnt_q   <= '0;
      lost_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      motor_q    <= motor_d;
      fault_q    <= fault_d;
      cur_duty_q <= cur_duty_d;
      pwm_cnt_q  <= pwm_cnt_d;
      oc_cnt_q   <= oc_cnt_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign motor    = motor_q;
  assign fault    = fault_q;
  assign state    = state_q;
  assign cur_duty = cur_duty_q;

endmodule

// File: tb/tb_pwm_line_drive.sv
// Bench for pwm_line_drive: directed scenarios plus random traffic,
// every cycle compared against a behavioural reference model.
module tb_pwm_line_drive;

  localparam int P   = 10;
  localparam int STP = 3;
  localparam int OCC = 5;
  localparam int LP  = 3;
  localparam int DW  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] duty;
  logic [3:0] ips;
  logic [1:0] oc_n;
  logic       clear_fault;
  logic [3:0] motor;
  logic [1:0] fault;
  logic [2:0] state;
  logic [3:0] cur_duty;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_line_drive #(
    .PWM_PERIOD(P), .RAMP_STEP(STP), .OC_CH(2),
    .OC_CYCLES(OCC), .LOST_PERIODS(LP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .duty(duty),
    .ips(ips), .oc_n(oc_n), .clear_fault(clear_fault),
    .motor(motor), .fault(fault), .state(state), .cur_duty(cur_duty)
  );

  // reference model: 0 idle 1 ramp 2 run 3 lost 4 fault; dir 0 none 1 left 2 right
  int m_state, m_cd, m_pc, m_lc, m_oc, m_fault, m_dir, m_motor;
  logic [3:0] s1, s2;
  logic [1:0] o1, o2;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int steer_code(input logic [3:0] v, input int dir,
                                    output int ndir);
    ndir = dir;
    if (v == 4'b0000) return (dir == 1) ? 8 : (dir == 2) ? 2 : 10;
    if (!v[3]) begin
      ndir = 1;
      return v[2] ? 9 : 8;
    end
    if (!v[0]) begin
      ndir = 2;
      return v[1] ? 6 : 2;
    end
    return (v == 4'b1111) ? 0 : 10;
  endfunction

  task automatic model_step();
    int tgt, ns, ncd, npc, nlc, noc, nfl, ndir, sc, lc_code;
    bit lost, wrp;
    if (rst) begin
      m_state = 0; m_cd = 0; m_pc = 0; m_lc = 0; m_oc = 0;
      m_fault = 0; m_dir = 0; m_motor = 0;
      s1 = 4'hF; s2 = 4'hF; o1 = 2'b11; o2 = 2'b11;
      return;
    end
    sc      = steer_code(s2, m_dir, ndir);
    lost    = (s2 == 4'hF);
    lc_code = (m_dir == 1) ? 9 : (m_dir == 2) ? 6 : 10;
    tgt     = (int'(duty) > P) ? P : int'(duty);
    wrp     = (m_pc == P - 1);
    ns = m_state; ncd = m_cd; nlc = m_lc; nfl = m_fault;
    npc = wrp ? 0 : m_pc + 1;
    noc = (o2 != 2'b11) ? ((m_oc + 1 > OCC) ? OCC : m_oc + 1) : 0;
    if (m_state == 4) begin
      if (clear_fault) begin
        ns = 0; nfl = 0; npc = 0; noc = 0;
      end
    end else if (m_oc == OCC) begin
      ns = 4; nfl = 1;
    end else if (m_state == 3 && wrp && m_lc + 1 == LP) begin
      ns = 4; nfl = 2;
    end else if (!enable) begin
      ns = 0;
    end else begin
      case (m_state)
        0: ns = 1;
        1: if (lost) ns = 3;
           else if (wrp) begin
             ncd = (m_cd + STP > tgt) ? tgt : m_cd + STP;
             if (ncd == tgt) ns = 2;
           end
        2: if (lost) ns = 3;
           else if (wrp) begin
             if (tgt > m_cd) ns = 1;
             else ncd = tgt;
           end
        default: if (!lost) ns = 2;
                 else if (wrp) nlc = m_lc + 1;
      endcase
    end
    if (ns != 3) nlc = 0;
    if (ns == 0 || ns == 4) ncd = 0;
    m_motor = 0;
    if (ns >= 1 && ns <= 3 && m_pc < m_cd) m_motor = (ns == 3) ? lc_code : sc;
    m_state = ns; m_cd = ncd; m_pc = npc; m_lc = nlc;
    m_oc = noc; m_fault = nfl; m_dir = ndir;
    s2 = s1; s1 = ips; o2 = o1; o1 = oc_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("state", state, m_state);
    check("motor", motor, m_motor);
    check("fault", fault, m_fault);
    check("cur_duty", cur_duty, m_cd);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_vals();
    check("rst_state", state, 0);
    check("rst_motor", motor, 0);
    check("rst_fault", fault, 0);
    check("rst_duty", cur_duty, 0);
  endtask

  logic [3:0] st_ips [5] = '{4'b0011, 4'b0111, 4'b1100, 4'b1110, 4'b0000};
  int         st_exp [5] = '{8, 9, 2, 6, 2};

  initial begin
    int cnt, burst;
    rst = 1'b1; enable = 1'b0; duty = '0; ips = 4'hF;
    oc_n = 2'b11; clear_fault = 1'b0;
    #1;
    ticks(3);
    check_reset_vals();
    rst = 1'b0;

    // soft start
    enable = 1'b1; duty = 4'd8; ips = 4'b1001;
    ticks(40);
    check("ss_state", state, 2);
    check("ss_duty", cur_duty, 8);
    cnt = 0;
    for (int i = 0; i < P; i++) begin
      tick();
      if (motor == 4'b1010) cnt++;
    end
    check("ss_on_cycles", cnt, 8);

    // clamp then step down
    duty = 4'd15;
    ticks(30);
    check("clamp_duty", cur_duty, 10);
    cnt = 0;
    for (int i = 0; i < P; i++) begin
      tick();
      if (motor == 4'b1010) cnt++;
    end
    check("clamp_on_cycles", cnt, 10);
    duty = 4'd2;
    ticks(15);
    check("step_down", cur_duty, 2);

    // steering at full duty
    duty = 4'd15;
    ticks(45);
    for (int i = 0; i < 5; i++) begin
      ips = st_ips[i];
      ticks(3);
      check("steer", motor, st_exp[i]);
      ticks(4);
    end

    // line lost after a left turn
    duty = 4'd8; ips = 4'b0111;
    ticks(12);
    ips = 4'b1111;
    ticks(3);
    check("lost_state", state, 3);
    cnt = 0;
    while (state != 3'd4 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("lost_trip", state, 4);
    check("lost_fault", fault, 2);
    check("lost_motor", motor, 0);
    ips = 4'b1001;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("clear_idle", state, 0);
    check("clear_fault", fault, 0);

    // over-current debounce
    ticks(20);
    oc_n = 2'b10;
    ticks(4);
    oc_n = 2'b11;
    ticks(10);
    check("oc_short", fault, 0);
    oc_n = 2'b01;
    cnt = 0;
    while (state != 3'd4 && cnt < 30) begin
      tick();
      cnt++;
    end
    check("oc_latency", cnt, OCC + 3);
    check("oc_fault", fault, 1);
    enable = 1'b0;
    ticks(3);
    enable = 1'b1;
    ticks(3);
    check("oc_hold", state, 4);
    rst = 1'b1;
    tick();
    check_reset_vals();
    rst = 1'b0; oc_n = 2'b11;
    ticks(5);

    // random traffic
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 99) < 96);
      if ($urandom_range(0, 39) == 0) duty = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 14) == 0) ips = 4'($urandom_range(0, 15));
      if (burst > 0) begin
        burst--;
        if (burst == 0) oc_n = 2'b11;
      end else if ($urandom_range(0, 99) == 0) begin
        burst = $urandom_range(1, 10);
        oc_n = 2'($urandom_range(0, 2));
      end
      clear_fault = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
